lvds_align_ctrl: RTL

Training controller for the 8-lane DDR LVDS ADC capture path. On request it puts the ADC into test-pattern mode and checks the assembled 16-bit `ADC_data` words against a known pattern. It issues bit-slip pulses to the capture deserializer until the pattern is received consistently, then reports lock or failure. It sits beside `LVDS_capture`, in the same capture clock domain.

---
 rtl/lvds_align_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lvds_align_ctrl.sv
// lvds_align_ctrl: bit-slip training controller for the 8-lane DDR LVDS ADC
// capture path. It puts the ADC in test-pattern mode, compares assembled
// words against PATTERN, slips the deserializer until the pattern holds for
// MATCH_COUNT consecutive valid words, then reports lock or failure.
// Optional feature macro: LVDS_ALIGN_SWAP_EN. When it is defined, a second
// round of slips is tried with the even/odd byte swap enabled before giving up.
module lvds_align_ctrl #(
  parameter logic [15:0] PATTERN       = 16'hA55A,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MATCH_COUNT   = 16,
  parameter int unsigned MAX_SLIPS     = 4
) (
  input  logic        clk_out,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ADC_data,
  input  logic        adc_valid,
  output logic        train_mode,
  output logic        bitslip,
  output logic        swap,
  output logic        busy,
  output logic        locked,
  output logic        fail,
  output logic [3:0]  slip_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    SLIP   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MATCH_LAST   = 8'(MATCH_COUNT - 1);
  localparam logic [3:0] MAX_SLIP_CNT = 4'(MAX_SLIPS);

  state_t     state_q, state_d;
  logic [3:0] slip_cnt_q, slip_cnt_d;
  logic [7:0] match_cnt_q, match_cnt_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic       train_mode_q, train_mode_d;
  logic       bitslip_q, bitslip_d;
  logic       busy_q, busy_d;
  logic       locked_q, locked_d;
  logic       fail_q, fail_d;
  logic       swap_q, swap_d;

  // Next-state, counter updates and registered-output decode of the next state.
  always_comb begin
    state_d      = state_q;
    slip_cnt_d   = slip_cnt_q;
    match_cnt_d  = match_cnt_q;
    settle_cnt_d = settle_cnt_q;
    swap_d       = swap_q;

    unique case (state_q)
      IDLE, LOCKED, FAIL: begin
        if (start) begin
          state_d      = SETTLE;
          slip_cnt_d   = '0;
          match_cnt_d  = '0;
          settle_cnt_d = '0;
          swap_d       = 1'b0;
        end
      end
      SETTLE: begin
        if (adc_valid) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            state_d      = CHECK;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
      end
      CHECK: begin
        if (adc_valid) begin
          if (ADC_data == PATTERN) begin
            match_cnt_d = match_cnt_q + 8'd1;
            if (match_cnt_q == MATCH_LAST) begin
              state_d = LOCKED;
            end
          end else begin
            match_cnt_d  = '0;
            settle_cnt_d = '0;
            if (slip_cnt_q < MAX_SLIP_CNT) begin
              state_d    = SLIP;
              slip_cnt_d = slip_cnt_q + 4'd1;
            end else begin
`ifdef LVDS_ALIGN_SWAP_EN
              if (!swap_q) begin
                swap_d     = 1'b1;
                slip_cnt_d = '0;
                state_d    = SETTLE;
              end else begin
                state_d = FAIL;
              end
`else
              state_d = FAIL;
`endif
            end
          end
        end
      end
      SLIP: begin
        state_d = SETTLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == FAIL) begin
      swap_d = 1'b0;
    end
`ifndef LVDS_ALIGN_SWAP_EN
    swap_d = 1'b0;
`endif

    busy_d       = (state_d == SETTLE) || (state_d == CHECK) || (state_d == SLIP);
    train_mode_d = busy_d;
    bitslip_d    = (state_d == SLIP);
    locked_d     = (state_d == LOCKED);
    fail_d       = (state_d == FAIL);
  end

  // State, counters and output registers; reset truncates any slip pulse.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slip_cnt_q   <= '0;
      match_cnt_q  <= '0;
      settle_cnt_q <= '0;
      swap_q       <= 1'b0;
      train_mode_q <= 1'b0;
      bitslip_q    <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slip_cnt_q   <= slip_cnt_d;
      match_cnt_q  <= match_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      swap_q       <= swap_d;
      train_mode_q <= train_mode_d;
      bitslip_q    <= bitslip_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign train_mode = train_mode_q;
  assign bitslip    = bitslip_q;
  assign swap       = swap_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign slip_cnt   = slip_cnt_q;

endmodule
